// File: rtl/check_colour_if.sv
// Piece-code inputs and colour-rule result outputs for check_colour.
interface check_colour_if;
  logic [3:0] currentPiece;
  logic [3:0] targetPiece;
  logic       allowColour;
  logic       isCapture;
  logic       targetEmpty;
  logic       pieceError;

  // Driver side: supplies piece codes, observes results.
  modport master (
    output currentPiece,
    output targetPiece,
    input  allowColour,
    input  isCapture,
    input  targetEmpty,
    input  pieceError
  );

  // Checker side: consumes piece codes, produces registered results.
  modport slave (
    input  currentPiece,
    input  targetPiece,
    output allowColour,
    output isCapture,
    output targetEmpty,
    output pieceError
  );
endinterface

// File: rtl/check_colour.sv
// Colour-rule checker for a chess move: decodes the moving piece and the
// destination contents, and registers allow/capture/empty/error flags with
// one cycle of latency. The only state is the four output registers.
module check_colour (
  input logic           clk,
  input logic           reset,
  check_colour_if.slave bus
);

  logic w_cur_valid;
  logic w_cur_illegal;
  logic w_tgt_valid;
  logic w_tgt_illegal;
  logic w_tgt_empty;
  logic w_allow;
  logic w_capture;
  logic w_error;

  logic r_allow;
  logic r_capture;
  logic r_empty;
  logic r_error;

  // Classify both codes and evaluate the colour rule combinationally.
  always_comb begin
    w_cur_valid   = (bus.currentPiece[2:0] >= 3'd1) && (bus.currentPiece[2:0] <= 3'd6);
    w_cur_illegal = (bus.currentPiece[2:0] == 3'b111) || (bus.currentPiece == 4'b1000);
    w_tgt_valid   = (bus.targetPiece[2:0] >= 3'd1) && (bus.targetPiece[2:0] <= 3'd6);
    w_tgt_illegal = (bus.targetPiece[2:0] == 3'b111) || (bus.targetPiece == 4'b1000);
    w_tgt_empty   = (bus.targetPiece == 4'b0000);
    w_error       = w_cur_illegal || w_tgt_illegal;
    // Illegal codes are neither valid nor empty, so they already force allow low.
    w_allow       = w_cur_valid &&
                    (w_tgt_empty ||
                     (w_tgt_valid && (bus.targetPiece[3] != bus.currentPiece[3])));
    w_capture     = w_allow && w_tgt_valid;
  end

  // Register all four results together; reset clears them as a group.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_allow   <= 1'b0;
      r_capture <= 1'b0;
      r_empty   <= 1'b0;
      r_error   <= 1'b0;
    end else begin
      r_allow   <= w_allow;
      r_capture <= w_capture;
      r_empty   <= w_tgt_empty;
      r_error   <= w_error;
    end
  end

  assign bus.allowColour = r_allow;
  assign bus.isCapture   = r_capture;
  assign bus.targetEmpty = r_empty;
  assign bus.pieceError  = r_error;

endmodule

// File: tb/tb_check_colour.sv
// Self-checking bench for check_colour: directed vector table, reset and
// latency sequences, and an exhaustive 256-combination sweep.
module tb_check_colour;

  logic clk;
  logic reset;
  int unsigned errors;
  int unsigned checks;

  check_colour_if bus ();

  check_colour dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected flags packed as {allowColour, isCapture, targetEmpty, pieceError}.
  typedef struct {
    logic [3:0] cur;
    logic [3:0] tgt;
    logic [3:0] exp;
    string      name;
  } vec_t;

  vec_t vecs[$];

  function automatic logic [3:0] got_flags();
    return {bus.allowColour, bus.isCapture, bus.targetEmpty, bus.pieceError};
  endfunction

  function automatic void check(input string name, input logic [3:0] exp);
    logic [3:0] act;
    act = got_flags();
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got {allow,cap,empty,err}=%b expected %b", name, act, exp);
    end
  endfunction

  // Reference written from the piece table rather than range compares.
  function automatic logic [3:0] model(input logic [3:0] c, input logic [3:0] t);
    bit c_valid, t_valid, c_bad, t_bad, t_empty, allow, cap;
    case (c[2:0])
      3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6: c_valid = 1;
      default:                            c_valid = 0;
    endcase
    case (t[2:0])
      3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6: t_valid = 1;
      default:                            t_valid = 0;
    endcase
    c_bad   = (c == 4'b1000) || (c == 4'b0111) || (c == 4'b1111);
    t_bad   = (t == 4'b1000) || (t == 4'b0111) || (t == 4'b1111);
    t_empty = (t == 4'b0000);
    allow   = 0;
    if (c_valid && !c_bad && !t_bad) begin
      if (t_empty) allow = 1;
      else if (t_valid && (c[3] ^ t[3])) allow = 1;
    end
    cap = allow && t_valid;
    return {allow, cap, t_empty, c_bad | t_bad};
  endfunction

  task automatic drive(input logic [3:0] c, input logic [3:0] t);
    @(negedge clk);
    bus.currentPiece = c;
    bus.targetPiece  = t;
  endtask

  task automatic edge_then_sample();
    @(posedge clk);
    #1;
  endtask

  initial begin
    errors = 0;
    checks = 0;
    reset  = 1'b1;
    bus.currentPiece = 4'b0000;
    bus.targetPiece  = 4'b0000;

    vecs.push_back('{4'b0001, 4'b0000, 4'b1010, "wpawn_to_empty"});
    vecs.push_back('{4'b0100, 4'b1110, 4'b1100, "wrook_x_bking"});
    vecs.push_back('{4'b1010, 4'b1011, 4'b0000, "bknight_on_bbishop"});
    vecs.push_back('{4'b0000, 4'b1001, 4'b0000, "empty_current"});
    vecs.push_back('{4'b0111, 4'b0001, 4'b0001, "illegal_cur_0111"});
    vecs.push_back('{4'b0111, 4'b0000, 4'b0011, "illegal_cur_empty_tgt"});
    vecs.push_back('{4'b1000, 4'b0001, 4'b0001, "illegal_cur_1000"});
    vecs.push_back('{4'b0001, 4'b1000, 4'b0001, "illegal_tgt_1000"});
    vecs.push_back('{4'b1001, 4'b1111, 4'b0001, "illegal_tgt_1111"});
    vecs.push_back('{4'b1110, 4'b0110, 4'b1100, "bking_x_wking"});
    vecs.push_back('{4'b0101, 4'b0011, 4'b0000, "wqueen_on_wbishop"});
    vecs.push_back('{4'b1101, 4'b0000, 4'b1010, "bqueen_to_empty"});
    vecs.push_back('{4'b0000, 4'b0000, 4'b0010, "both_empty"});

    // Reset with a legal move presented: outputs must stay zero.
    drive(4'b0001, 4'b0000);
    reset = 1'b1;
    edge_then_sample();
    check("reset_clears", 4'b0000);

    // First edge with reset low reflects the inputs at that edge.
    @(negedge clk);
    reset = 1'b0;
    edge_then_sample();
    check("first_after_reset", 4'b1010);

    // Directed table.
    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].cur, vecs[i].tgt);
      edge_then_sample();
      check(vecs[i].name, vecs[i].exp);
    end

    // No combinational path: change inputs, outputs hold until the next edge.
    drive(4'b0100, 4'b1110);
    edge_then_sample();
    check("capture_registered", 4'b1100);
    @(negedge clk);
    bus.currentPiece = 4'b0111;
    bus.targetPiece  = 4'b0000;
    #2;
    check("hold_before_edge", 4'b1100);
    edge_then_sample();
    check("update_after_edge", 4'b0011);

    // Mid-stream reset discards the pending result entirely.
    drive(4'b0100, 4'b1110);
    reset = 1'b1;
    edge_then_sample();
    check("midstream_reset", 4'b0000);
    @(negedge clk);
    reset = 1'b0;
    bus.currentPiece = 4'b1011;
    bus.targetPiece  = 4'b0010;
    edge_then_sample();
    check("resume_after_reset", 4'b1100);

    // Exhaustive sweep: current increments each cycle, target every 16.
    for (int t = 0; t < 16; t++) begin
      for (int c = 0; c < 16; c++) begin
        logic [3:0] cc, tt;
        cc = 4'(c);
        tt = 4'(t);
        drive(cc, tt);
        edge_then_sample();
        check($sformatf("sweep_c%0h_t%0h", cc, tt), model(cc, tt));
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Hard time limit so the run always terminates.
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, checks=%0d", checks);
    $fatal(1, "timeout");
  end

endmodule
